// File: rtl/lebug_pkg.sv
// Shared definitions for the lebug trace pipeline: configuration ids and
// the vector packer's pad-mode encoding.
package lebug_pkg;

    localparam logic [7:0] PACKER_CFG_ID = 8'd1;

    typedef enum logic {
        ZERO_PAD = 1'b0,
        DROP     = 1'b1
    } pad_mode_e;

endpackage

// File: rtl/vector_packer.sv
// Packs M scalars per cycle into N-lane vectors, flushing partial vectors on
// end-of-frame either zero-padded or dropped depending on the configured pad mode.
module vector_packer
    import lebug_pkg::*;
#(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int M          = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           valid_in,
    input  logic                           eof_in,
    input  logic                           tracing,
    input  logic [7:0]                     configId,
    input  logic [7:0]                     configData,
    input  logic [M-1:0][DATA_WIDTH-1:0]   scalar_in,
    output logic                           enqueue,
    output logic                           eof_out,
    output logic [N-1:0][DATA_WIDTH-1:0]   vector_out
);

    localparam int SLOTS = N / M;
    localparam int KW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [KW-1:0] LAST_SLOT = KW'(SLOTS - 1);

    logic [KW-1:0]                 k_q, k_d, k_adv;
    logic [N-1:0][DATA_WIDTH-1:0]  staging_q, staging_d, padded;
    logic [N-1:0][DATA_WIDTH-1:0]  vector_q, vector_d;
    logic                          enqueue_q, enqueue_d;
    logic                          eof_q, eof_d;
    pad_mode_e                     pad_mode_q, pad_mode_d;

    logic accept;
    logic flush;
    logic complete;

    assign accept   = valid_in && tracing;
    assign flush    = eof_in && tracing;
    assign complete = accept && (k_q == LAST_SLOT);

    // staging_d is the staging content including this cycle's chunk; padded
    // keeps only lanes belonging to slots already filled (after this write).
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        localparam logic [KW-1:0] LANE_SLOT = KW'(gi / M);
        assign staging_d[gi] = (accept && (k_q == LANE_SLOT)) ? scalar_in[gi % M]
                                                              : staging_q[gi];
        assign padded[gi]    = (LANE_SLOT < k_adv) ? staging_d[gi] : '0;
    end

    always_comb begin
        k_adv = k_q;
        if (accept) begin
            k_adv = (k_q == LAST_SLOT) ? '0 : k_q + KW'(1);
        end
    end

    always_comb begin
        k_d        = k_adv;
        enqueue_d  = 1'b0;
        eof_d      = 1'b0;
        vector_d   = vector_q;
        pad_mode_d = pad_mode_q;

        if (configId == PACKER_CFG_ID) begin
            pad_mode_d = pad_mode_e'(configData[0]);
        end

        // A completing chunk absorbs a coincident eof: one vector, flagged.
        if (complete) begin
            enqueue_d = 1'b1;
            eof_d     = flush;
            vector_d  = staging_d;
        end else if (flush) begin
            eof_d = 1'b1;
            k_d   = '0;
            if ((k_adv != '0) && (pad_mode_q == ZERO_PAD)) begin
                enqueue_d = 1'b1;
                vector_d  = padded;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k_q        <= '0;
            staging_q  <= '0;
            vector_q   <= '0;
            enqueue_q  <= 1'b0;
            eof_q      <= 1'b0;
            pad_mode_q <= ZERO_PAD;
        end else begin
            k_q        <= k_d;
            staging_q  <= staging_d;
            vector_q   <= vector_d;
            enqueue_q  <= enqueue_d;
            eof_q      <= eof_d;
            pad_mode_q <= pad_mode_d;
        end
    end

    assign enqueue    = enqueue_q;
    assign eof_out    = eof_q;
    assign vector_out = vector_q;

endmodule

// File: tb/tb_vector_packer.sv
// Directed and randomized checks of vector_packer against a queue-based
// model of the packing/flush rules.
module tb_vector_packer;

    localparam int N  = 8;
    localparam int M  = 2;
    localparam int DW = 32;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  valid_in = 1'b0;
    logic                  eof_in = 1'b0;
    logic                  tracing = 1'b0;
    logic [7:0]            configId = 8'd0;
    logic [7:0]            configData = 8'd0;
    logic [M-1:0][DW-1:0]  scalar_in = '0;
    logic                  enqueue;
    logic                  eof_out;
    logic [N-1:0][DW-1:0]  vector_out;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0]         pending[$];
    logic                  mdl_pad = 1'b0;
    logic                  exp_enq = 1'b0;
    logic                  exp_eof = 1'b0;
    logic [N-1:0][DW-1:0]  exp_vec = '0;
    int                    enq_count = 0;

    vector_packer #(.N(N), .DATA_WIDTH(DW), .M(M)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .eof_in     (eof_in),
        .tracing    (tracing),
        .configId   (configId),
        .configData (configData),
        .scalar_in  (scalar_in),
        .enqueue    (enqueue),
        .eof_out    (eof_out),
        .vector_out (vector_out)
    );

    always #5 clk = ~clk;

    // Reference: scalars accumulate in a queue; a full queue becomes a vector,
    // an eof empties it (padded or discarded according to the old pad mode).
    task automatic model(input logic r, input logic v, input logic e, input logic tr,
                         input logic [7:0] cid, input logic [7:0] cdat,
                         input logic [DW-1:0] s0, input logic [DW-1:0] s1);
        if (!r) begin
            pending.delete();
            mdl_pad = 1'b0;
            exp_enq = 1'b0;
            exp_eof = 1'b0;
            exp_vec = '0;
        end else begin
            exp_enq = 1'b0;
            exp_eof = 1'b0;
            if (tr && v) begin
                pending.push_back(s0);
                pending.push_back(s1);
            end
            if (tr && v && pending.size() == N) begin
                for (int i = 0; i < N; i++) exp_vec[i] = pending[i];
                exp_enq = 1'b1;
                exp_eof = e;
                pending.delete();
            end else if (tr && e) begin
                exp_eof = 1'b1;
                if (pending.size() != 0 && mdl_pad == 1'b0) begin
                    exp_enq = 1'b1;
                    for (int i = 0; i < N; i++)
                        exp_vec[i] = (i < pending.size()) ? pending[i] : '0;
                end
                pending.delete();
            end
            if (cid == 8'd1) mdl_pad = cdat[0];
        end
    endtask

    task automatic step(input string tag, input logic r, input logic v, input logic e,
                        input logic tr, input logic [7:0] cid, input logic [7:0] cdat,
                        input logic [DW-1:0] s0, input logic [DW-1:0] s1);
        rst_n        = r;
        valid_in     = v;
        eof_in       = e;
        tracing      = tr;
        configId     = cid;
        configData   = cdat;
        scalar_in[0] = s0;
        scalar_in[1] = s1;
        model(r, v, e, tr, cid, cdat, s0, s1);
        @(posedge clk);
        #1;
        if (enqueue === 1'b1) enq_count++;
        total++;
        assert (enqueue === exp_enq) else begin
            bad++;
            $error("FAIL %s enqueue got %0b want %0b", tag, enqueue, exp_enq);
        end
        total++;
        assert (eof_out === exp_eof) else begin
            bad++;
            $error("FAIL %s eof_out got %0b want %0b", tag, eof_out, exp_eof);
        end
        total++;
        assert (vector_out === exp_vec) else begin
            bad++;
            $error("FAIL %s vector_out got %h want %h", tag, vector_out, exp_vec);
        end
    endtask

    task automatic chunk(input string tag, input logic e, input logic [DW-1:0] s0,
                         input logic [DW-1:0] s1);
        step(tag, 1'b1, 1'b1, e, 1'b1, 8'd0, 8'd0, s0, s1);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, '0, '0);
    endtask

    initial begin
        int cnt_before;
        // reset state
        step("reset0", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, '0, '0);
        step("reset1", 1'b0, 1'b1, 1'b1, 1'b1, 8'd1, 8'd1, 32'hdead, 32'hbeef);
        idle("reset_idle");

        // basic pack
        chunk("basic_c1", 1'b0, 1, 2);
        chunk("basic_c2", 1'b0, 3, 4);
        chunk("basic_c3", 1'b0, 5, 6);
        chunk("basic_c4", 1'b0, 7, 8);
        idle("basic_out");
        idle("basic_hold");

        // zero-pad flush
        chunk("zpad_c1", 1'b0, 1, 2);
        chunk("zpad_c2", 1'b0, 3, 4);
        step("zpad_eof", 1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 8'd0, '0, '0);
        idle("zpad_out");
        chunk("zpad_k0_c1", 1'b0, 11, 12);
        chunk("zpad_k0_c2", 1'b0, 13, 14);
        chunk("zpad_k0_c3", 1'b0, 15, 16);
        chunk("zpad_k0_c4", 1'b0, 17, 18);
        idle("zpad_k0_out");

        // standalone eof with nothing pending
        step("lone_eof", 1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 8'd0, '0, '0);
        idle("lone_eof_out");

        // drop mode, config in same cycle as a chunk with the old mode still zero-pad
        step("drop_cfg", 1'b1, 1'b1, 1'b0, 1'b1, 8'd1, 8'd1, 32'h21, 32'h22);
        step("drop_eof", 1'b1, 1'b1, 1'b1, 1'b1, 8'd0, 8'd0, 32'h9, 32'h9);
        idle("drop_out");
        chunk("drop_c1", 1'b0, 31, 32);
        chunk("drop_c2", 1'b0, 33, 34);
        chunk("drop_c3", 1'b0, 35, 36);
        chunk("drop_c4", 1'b0, 37, 38);
        idle("drop_clean");

        // coincident eof with completing chunk
        chunk("coin_c1", 1'b0, 41, 42);
        chunk("coin_c2", 1'b0, 43, 44);
        chunk("coin_c3", 1'b0, 45, 46);
        chunk("coin_c4", 1'b1, 47, 48);
        idle("coin_out");
        idle("coin_no_extra");

        // tracing gap
        chunk("gap_c1", 1'b0, 51, 52);
        chunk("gap_c2", 1'b0, 53, 54);
        for (int i = 0; i < 5; i++)
            step("gap_off", 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 32'hbad0 + i, 32'hbad8 + i);
        chunk("gap_c3", 1'b0, 55, 56);
        chunk("gap_c4", 1'b0, 57, 58);
        idle("gap_out");

        // reset mid-fill, back to zero-pad via reset
        chunk("rst_c1", 1'b0, 61, 62);
        chunk("rst_c2", 1'b0, 63, 64);
        chunk("rst_c3", 1'b0, 65, 66);
        step("rst_pulse", 1'b0, 1'b1, 1'b1, 1'b1, 8'd0, 8'd0, 32'h77, 32'h77);
        cnt_before = enq_count;
        chunk("rst_c4", 1'b0, 71, 72);
        chunk("rst_c5", 1'b0, 73, 74);
        chunk("rst_c6", 1'b0, 75, 76);
        chunk("rst_c7", 1'b0, 77, 78);
        idle("rst_out");
        idle("rst_after");
        total++;
        assert (enq_count - cnt_before === 1) else begin
            bad++;
            $error("FAIL rst_enq_count got %0d want 1", enq_count - cnt_before);
        end

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic r, v, e, tr;
            logic [7:0] cid, cdat;
            r    = ($urandom_range(0, 99) >= 2);
            v    = ($urandom_range(0, 99) < 70);
            e    = ($urandom_range(0, 99) < 12);
            tr   = ($urandom_range(0, 99) < 85);
            cid  = ($urandom_range(0, 99) < 8) ? 8'd1 : 8'($urandom_range(0, 3) * 2);
            cdat = 8'($urandom);
            step("rand", r, v, e, tr, cid, cdat, $urandom, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vector_packer.md
VECTOR_PACKER -- requirements
Module: vector_packer

Interface
REQ-001 SHALL have parameter N, default 8: lanes per output vector.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: bits per lane.
REQ-003 SHALL have parameter M, default 2: scalars accepted per cycle; N%M==0 and N/M>=2 required.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on posedge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port valid_in, input, 1: scalar_in holds M valid scalars this cycle.
REQ-007 SHALL have port eof_in, input, 1: end-of-frame marker.
REQ-008 SHALL have port tracing, input, 1: packing enabled when high.
REQ-009 SHALL have port configId, input, 8: configuration target id.
REQ-010 SHALL have port configData, input, 8: configuration payload.
REQ-011 SHALL have port scalar_in, input, M x DATA_WIDTH: incoming scalars, element 0 first.
REQ-012 SHALL have port enqueue, output, 1: vector_out valid; drives the input buffer's enqueue.
REQ-013 SHALL have port eof_out, output, 1: end-of-frame aligned with the output.
REQ-014 SHALL have port vector_out, output, N x DATA_WIDTH: packed vector.

Function
REQ-015 SHALL keep slot counter k, range 0..N/M-1, and an N-lane staging register.
REQ-016 SHALL, on a cycle with valid_in&tracing, write scalar_in[j] to staging lane k*M+j, then advance k with wrap to 0.
REQ-017 SHALL, when the write fills slot N/M-1, assert enqueue for exactly 1 cycle on the next cycle, with vector_out = full staging (latency 1 from the final chunk).
REQ-018 SHALL hold vector_out stable until the next enqueue; enqueue and eof_out are single-cycle pulses.
REQ-019 SHALL hold pad_mode, 1 bit, written from configData[0] when configId==PACKER_CFG_ID; 0=ZERO_PAD, 1=DROP; the new value applies from the next cycle.
REQ-020 SHALL, on eof_in&tracing with a partial vector pending (k!=0 after any same-cycle write) in ZERO_PAD mode, emit next cycle: enqueue=1, eof_out=1, unfilled lanes=0.
REQ-021 SHALL, in DROP mode under the same condition, emit next cycle: enqueue=0, eof_out=1, and discard the partial vector.
REQ-022 SHALL, when eof_in coincides with the chunk that completes a vector, emit one enqueue with eof_out=1; no extra vector.
REQ-023 SHALL, on eof_in&tracing with k==0 and no completing chunk, emit a standalone eof_out=1, enqueue=0.
REQ-024 SHALL clear k to 0 after every eof flush.
REQ-025 SHALL, while tracing==0, ignore valid_in and eof_in, and hold k and staging contents unchanged.
REQ-026 SHALL accept a config write in the same cycle as data; the data is packed normally and the old pad_mode governs any flush in that cycle.
REQ-027 SHALL accept input every cycle: no backpressure; sustained rate is one vector per N/M valid cycles.

Reset
REQ-028 SHALL, on posedge clk with rst_n==0, set enqueue=0, eof_out=0, vector_out all 0, k=0, staging all 0, pad_mode=ZERO_PAD.
REQ-029 SHALL, on reset mid-fill, discard the partial vector and emit no enqueue or eof afterwards for it.
REQ-030 SHALL give reset priority over valid_in, eof_in and config writes in the same cycle.

Structure
REQ-031 SHALL take PACKER_CFG_ID (8'd1) and the pad-mode enum {ZERO_PAD, DROP} from the shared lebug package.
REQ-032 SHALL be a single module with no sub-module; counter, staging and output registers are inline.

Verification
REQ-033 Basic pack, N=8 M=2: 4 valid chunks {1,2},{3,4},{5,6},{7,8} -> enqueue 1 cycle after the 4th chunk, vector_out=1..8, eof_out=0.
REQ-034 Zero-pad flush: chunks {1,2},{3,4}, then eof_in alone -> enqueue=1, eof_out=1, vector_out={1,2,3,4,0,0,0,0}, k=0 afterwards.
REQ-035 Drop flush: configId=1, configData=1, then chunk {9,9} plus eof_in -> eof_out=1, enqueue=0; the next 4 chunks produce a clean vector.
REQ-036 Coincident eof: eof_in with the 4th chunk -> single enqueue with eof_out=1, and no follow-up pulse.
REQ-037 tracing gap: 2 chunks, tracing=0 for 5 cycles with valid_in=1, then 2 chunks -> one vector containing only the 4 traced chunks.
REQ-038 Reset mid-fill: 3 chunks, rst_n=0 for 1 cycle, then 4 chunks -> outputs 0 during reset, exactly one enqueue carrying only the post-reset data.
